// File: rtl/mlp_pkg.sv
// Shared types and width helpers for the MLP layer scheduler.
// The default localparams describe the reference 5-neuron, 3-layer configuration.
package mlp_pkg;

    localparam int WIDTH     = 8;
    localparam int N_DEFAULT = 5;
    localparam int M_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WB,
        DONE
    } state_t;

    function automatic int widthMin1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int addrWidth(input int n, input int m);
        return widthMin1(m * n * (n + 1));
    endfunction

    // k runs 0..N inclusive, so it needs one more code than x_sel does
    function automatic int kWidth(input int n);
        return widthMin1(n + 1);
    endfunction

    function automatic int idxWidth(input int n);
        return widthMin1(n);
    endfunction

    function automatic int layerWidth(input int m);
        return widthMin1(m);
    endfunction

    localparam int AW = addrWidth(N_DEFAULT, M_DEFAULT);
    localparam int KW = kWidth(N_DEFAULT);
    localparam int XW = idxWidth(N_DEFAULT);
    localparam int LW = layerWidth(M_DEFAULT);

endpackage

// File: rtl/mlp_loop_counter.sv
// Nested k (operand), j (neuron) and l (layer) counters.
// Each wraps to 0 when it advances past its final value.
module mlp_loop_counter
    import mlp_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       kInc_i,
    input  logic                       nbInc_i,
    output logic [kWidth(N)-1:0]       k_o,
    output logic [idxWidth(N)-1:0]     j_o,
    output logic [layerWidth(M)-1:0]   l_o,
    output logic                       kLast_o,
    output logic                       jLast_o,
    output logic                       lLast_o
);

    localparam int KW = kWidth(N);
    localparam int JW = idxWidth(N);
    localparam int LW = layerWidth(M);

    logic [KW-1:0] k_q, k_d;
    logic [JW-1:0] j_q, j_d;
    logic [LW-1:0] l_q, l_d;

    assign kLast_o = (k_q == KW'(N));
    assign jLast_o = (j_q == JW'(N - 1));
    assign lLast_o = (l_q == LW'(M - 1));

    assign k_o = k_q;
    assign j_o = j_q;
    assign l_o = l_q;

    // nbInc advances the neuron index and carries into the layer index
    always_comb begin
        k_d = k_q;
        j_d = j_q;
        l_d = l_q;
        if (kInc_i) begin
            k_d = kLast_o ? '0 : k_q + KW'(1);
        end
        if (nbInc_i) begin
            if (jLast_o) begin
                j_d = '0;
                l_d = lLast_o ? '0 : l_q + LW'(1);
            end else begin
                j_d = j_q + JW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_q <= '0;
            j_q <= '0;
            l_q <= '0;
        end else begin
            k_q <= k_d;
            j_q <= j_d;
            l_q <= l_d;
        end
    end

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Sequences weight reads, MAC operations and activation write-back
// for an M-layer, N-neuron MLP using ping-pong activation buffers.
module mlp_layer_scheduler
    import mlp_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       soc_i,
    output logic                       busy_o,
    output logic                       eoc_o,
    output logic                       wmem_rd_en_o,
    output logic [addrWidth(N,M)-1:0]  wmem_addr_o,
    output logic                       mac_clr_o,
    output logic                       mac_en_o,
    output logic [idxWidth(N)-1:0]     x_sel_o,
    output logic                       bias_sel_o,
    output logic                       src_ext_o,
    output logic                       rd_buf_o,
    output logic                       act_wr_en_o,
    output logic [idxWidth(N)-1:0]     act_wr_idx_o,
    output logic                       wr_buf_o,
    output logic [layerWidth(M)-1:0]   layer_idx_o
);

    localparam int AW = addrWidth(N, M);
    localparam int KW = kWidth(N);
    localparam int XW = idxWidth(N);
    localparam int LW = layerWidth(M);
    localparam logic [AW-1:0] L_STRIDE = AW'(N * (N + 1));
    localparam logic [AW-1:0] J_STRIDE = AW'(N + 1);

    state_t state_q, state_d;

    logic [KW-1:0] k;
    logic [XW-1:0] j;
    logic [LW-1:0] l;
    logic          kLast, jLast, lLast;
    logic          rdEn, inWb, active;
    logic [AW-1:0] addrNow;

    logic          macEn_q;
    logic          biasSel_q;
    logic [XW-1:0] xSel_q;
    logic [AW-1:0] addrHold_q;
    logic [XW-1:0] wrIdxHold_q;

    mlp_loop_counter #(.N(N), .M(M)) u_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .kInc_i  (rdEn),
        .nbInc_i (inWb),
        .k_o     (k),
        .j_o     (j),
        .l_o     (l),
        .kLast_o (kLast),
        .jLast_o (jLast),
        .lLast_o (lLast)
    );

    assign rdEn    = (state_q == MAC);
    assign inWb    = (state_q == WB);
    assign active  = (state_q == MAC) || (state_q == DRAIN) || (state_q == WB);
    assign addrNow = AW'(l) * L_STRIDE + AW'(j) * J_STRIDE + AW'(k);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (soc_i) state_d = MAC;
            MAC:     if (kLast) state_d = DRAIN;
            DRAIN:   state_d = WB;
            WB:      state_d = (jLast && lLast) ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MAC-side strobes trail the weight read by the memory's one-cycle latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            macEn_q     <= 1'b0;
            biasSel_q   <= 1'b0;
            xSel_q      <= '0;
            addrHold_q  <= '0;
            wrIdxHold_q <= '0;
        end else begin
            state_q   <= state_d;
            macEn_q   <= rdEn;
            biasSel_q <= rdEn && kLast;
            if (rdEn && !kLast) xSel_q <= k[XW-1:0];
            if (rdEn) addrHold_q <= addrNow;
            if (inWb) wrIdxHold_q <= j;
        end
    end

    // Buffer routing is only meaningful while a layer is in flight
    always_comb begin
        busy_o       = (state_q != IDLE);
        eoc_o        = (state_q == DONE);
        wmem_rd_en_o = rdEn;
        wmem_addr_o  = rdEn ? addrNow : addrHold_q;
        mac_clr_o    = rdEn && (k == '0);
        mac_en_o     = macEn_q;
        x_sel_o      = xSel_q;
        bias_sel_o   = biasSel_q;
        act_wr_en_o  = inWb;
        act_wr_idx_o = inWb ? j : wrIdxHold_q;
        layer_idx_o  = l;
        src_ext_o    = active && (l == '0);
        rd_buf_o     = active && (l != '0) && !l[0];
        wr_buf_o     = active && l[0];
    end

endmodule

// File: doc/mlp_layer_scheduler.md
MLP_LAYER_SCHEDULER -- requirements
Module: mlp_layer_scheduler

Interface
REQ-001 Parameters SHALL be: N, default 5, neurons per layer and inputs per neuron; M, default 3, number of layers; WIDTH, default 8, data width carried in the shared package only.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 soc  input  1  start of computation; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 eoc  output  1  end of computation; one-cycle pulse.
REQ-007 wmem_rd_en  output  1  weight-memory read strobe; the memory has 1-cycle read latency.
REQ-008 wmem_addr  output  AW=$clog2(M*N*(N+1))  weight/bias word address.
REQ-009 mac_clr  output  1  clears the datapath accumulator.
REQ-010 mac_en  output  1  accumulate the current operand pair.
REQ-011 x_sel  output  $clog2(N)  operand index k for the current mac_en.
REQ-012 bias_sel  output  1  the current mac_en adds the bias word; x_sel is don't-care.
REQ-013 src_ext  output  1  layer operands come from the external input vector (layer 0).
REQ-014 rd_buf  output  1  ping-pong activation buffer being read (valid when src_ext=0).
REQ-015 act_wr_en  output  1  write the activated neuron result.
REQ-016 act_wr_idx  output  $clog2(N)  neuron index j being written.
REQ-017 wr_buf  output  1  ping-pong buffer being written.
REQ-018 layer_idx  output  $clog2(M) (min 1)  current layer l.

Function
REQ-019 The states SHALL be IDLE, MAC, DRAIN, WB and DONE.
REQ-020 IDLE->MAC when soc=1; DONE->IDLE unconditionally after 1 cycle.
REQ-021 MAC SHALL last N+1 cycles with counter k=0..N; each cycle asserts wmem_rd_en with wmem_addr=l*N*(N+1)+j*(N+1)+k.
REQ-022 mac_clr SHALL be high only in the MAC cycle with k=0.
REQ-023 mac_en, x_sel and bias_sel SHALL be the 1-cycle-delayed copies of wmem_rd_en, k and (k==N) respectively, so the last mac_en falls in DRAIN.
REQ-024 WB SHALL last 1 cycle with act_wr_en=1 and act_wr_idx=j.
REQ-025 After WB: if j<N-1, then j+1 and go to MAC; else if l<M-1, then j=0, l+1 and go to MAC; else go to DONE.
REQ-026 Each neuron SHALL take N+3 cycles; eoc SHALL be high exactly M*N*(N+3) cycles after the edge that samples soc (120 cycles for N=5, M=3).
REQ-027 Buffer routing SHALL be: src_ext=(l==0); rd_buf=(l-1)%2; wr_buf=l%2. The final result therefore resides in buffer (M-1)%2.
REQ-028 soc SHALL be ignored while busy=1. soc held high through DONE restarts the block one cycle after IDLE is entered.
REQ-029 Counters k, j and l SHALL wrap to 0 when leaving their final value; wmem_addr SHALL never exceed M*N*(N+1)-1.
REQ-030 Outside the cycles stated above, every strobe SHALL be 0 and every index output SHALL hold its last value.

Reset
REQ-031 rst=1 SHALL, on the next edge, force IDLE and k=j=l=0. All 1-bit outputs SHALL then be 0, all index and address outputs 0, and busy and eoc 0.
REQ-032 rst SHALL override soc in the same cycle. rst during MAC, DRAIN or WB SHALL abort without any trailing mac_en or act_wr_en.
REQ-033 After reset release, the first soc SHALL behave exactly as in REQ-026.

Structure
REQ-034 Package mlp_pkg SHALL hold the state enum, WIDTH, and the localparams for AW and the index widths derived from N and M.
REQ-035 One sub-module, mlp_loop_counter, SHALL implement the k/j/l nested counters with wrap and last-value flags. The FSM and delay registers SHALL reside in mlp_layer_scheduler.

Verification
REQ-036 Scenarios (N=5, M=3):
- Reset then soc pulse -> eoc pulse exactly 120 cycles later; 15 act_wr_en pulses; 90 rd_en cycles with addresses 0..89 in order.
- Per neuron -> mac_clr once; 6 mac_en cycles with x_sel 0..4 then bias_sel=1; act_wr_en 2 cycles after the last rd_en.
- Layer routing -> src_ext=1 for l=0; rd_buf/wr_buf = x/0, 0/1, 1/0 for l=0,1,2.
- soc pulsed at cycle 40 during busy -> ignored; eoc still at cycle 120; no restart.
- rst asserted at cycle 57 with soc=1 -> next cycle IDLE, all outputs 0; subsequent soc yields eoc 120 cycles later.
- soc held high continuously -> eoc at 120; busy again 2 cycles later; second eoc at 242.
